axi_ram_arbiter: RTL and testbench
==================================

Name: axi_ram_arbiter

Overview:
Grants ownership of the shared AXI RAM slave's write path and read path to one of NUM_MST requesters each. Write and read arbitration are independent and round-robin. A grant is held from the address handshake until the burst completes. External muxing of the AXI channels is steered by the one-hot grant vectors. A watchdog releases a grant when the slave or master stalls too long.

Parameters:
NUM_MST, 2, number of requesting masters (2..8)
TIMEOUT, 256, cycles a grant may stay in one state without progress before forced release (>=4)

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
wr_req  in  NUM_MST  per-master write request, held until granted
wr_gnt  out  NUM_MST  one-hot write grant, registered
wr_owner  out  $clog2(NUM_MST)  index of current write owner (valid when wr_gnt!=0)
rd_req  in  NUM_MST  per-master read request
rd_gnt  out  NUM_MST  one-hot read grant, registered
rd_owner  out  $clog2(NUM_MST)  index of current read owner
awvalid, awready  in  1  slave-side AW handshake (muxed)
bvalid, bready  in  1  slave-side B handshake
arvalid, arready  in  1  slave-side AR handshake
rvalid, rready, rlast  in  1  slave-side R handshake
wr_timeout  out  1  one-cycle pulse on forced write release
rd_timeout  out  1  one-cycle pulse on forced read release

Behaviour:
- Reset: wr_gnt=0, rd_gnt=0, wr_owner=0, rd_owner=0, wr_timeout=0, rd_timeout=0. Both FSMs go to IDLE, both RR pointers go to 0, watchdog counters clear. A reset mid-burst drops the grant on the next edge.
- Write FSM states: W_IDLE, W_ADDR, W_RESP.
  - W_IDLE: if wr_req!=0, pick the first set bit searching from ptr upward with wrap. On the same edge, set wr_gnt one-hot and wr_owner, then go to W_ADDR. Grant latency is 1 cycle from request.
  - W_ADDR: on awvalid&awready, go to W_RESP. If wr_req[owner] drops before the AW handshake, clear the grant and go to W_IDLE without moving ptr.
  - W_RESP: wr_req is ignored. On bvalid&bready, clear the grant, set ptr=(owner+1)%NUM_MST, and go to W_IDLE.
- Read FSM states: R_IDLE, R_ADDR, R_DATA. Same rules as the write FSM using rd_req, arvalid&arready, and rvalid&rready&rlast as the completion event.
- Minimum one IDLE cycle between consecutive grants on a path. Grants are never back-to-back, so the external mux switches cleanly.
- Write and read paths run concurrently. The same master may hold wr_gnt and rd_gnt at once.
- Watchdog: one counter per path. It clears on any state change and on any handshake beat (rvalid&rready for read). Otherwise it increments in ADDR/DATA/RESP states. When it reaches TIMEOUT-1:
  - clear the grant and go to IDLE
  - ptr=(owner+1)%NUM_MST
  - pulse *_timeout for 1 cycle
- A simultaneous completion and timeout counts as completion, with no timeout pulse.
- Pointer arithmetic wraps at NUM_MST (not a power of 2 in general). An owner index of NUM_MST-1 yields ptr 0.
- wr_gnt/rd_gnt are always zero or one-hot. The grant vectors are never combinationally dependent on the inputs.

Test Plan:
- Reset, then wr_req=2'b11 → wr_gnt=2'b01 one cycle later. After AW and B handshakes, wr_gnt=0 for 1 cycle, then 2'b10 (round-robin).
- Read burst ARLEN=3 for master 1 with rd_req=2'b10 → rd_gnt=2'b10 through 4 R beats. Released only after the beat with rlast; rd_gnt=0 the next cycle.
- Concurrent wr_req=2'b01 and rd_req=2'b10 in the same cycle → wr_gnt=2'b01 and rd_gnt=2'b10 both assert on the next edge, with independent completion.
- TIMEOUT=8, grant master 0 write, no awready → after 8 stalled cycles, wr_timeout pulses 1 cycle, wr_gnt=0, and the next grant goes to master 1 if requesting.
- wr_req[0] dropped in W_ADDR before the AW handshake → wr_gnt clears next edge and ptr stays 0. A later wr_req=2'b11 grants master 0.
- aresetn low for 1 cycle during W_RESP → wr_gnt=0 and ptr=0. After reset, wr_req=2'b10 → wr_gnt=2'b10.

Source files
------------

// File: rtl/axi_ram_arbiter.sv
// Round-robin owner arbiter for the shared AXI RAM slave; independent write and read paths.
// Latency: grant registered 1 cycle after request; released the edge after B / last R beat, or on watchdog expiry.
// Backpressure: a grant is held across slave/master stalls until completion, request drop in ADDR, or TIMEOUT stalled cycles.
// Ports: aclk/aresetn (sync, active-low); i_wr_req/o_wr_gnt/o_wr_owner and i_rd_req/o_rd_gnt/o_rd_owner;
//        muxed slave handshakes i_aw*/i_b*/i_ar*/i_r*; o_wr_timeout/o_rd_timeout one-cycle forced-release pulses.
module axi_ram_arbiter #(
   parameter int NUM_MST = 2,
   parameter int TIMEOUT = 256
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic [NUM_MST-1:0]         i_wr_req,
   output logic [NUM_MST-1:0]         o_wr_gnt,
   output logic [$clog2(NUM_MST)-1:0] o_wr_owner,
   input  logic [NUM_MST-1:0]         i_rd_req,
   output logic [NUM_MST-1:0]         o_rd_gnt,
   output logic [$clog2(NUM_MST)-1:0] o_rd_owner,
   input  logic                       i_awvalid,
   input  logic                       i_awready,
   input  logic                       i_bvalid,
   input  logic                       i_bready,
   input  logic                       i_arvalid,
   input  logic                       i_arready,
   input  logic                       i_rvalid,
   input  logic                       i_rready,
   input  logic                       i_rlast,
   output logic                       o_wr_timeout,
   output logic                       o_rd_timeout
);
   localparam int OW = $clog2(NUM_MST);
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

   // First requester at or above ptr, wrapping at NUM_MST (need not be a power of 2).
   function automatic logic [OW-1:0] f_rr_pick(input logic [NUM_MST-1:0] req, input logic [OW-1:0] ptr);
      logic [OW-1:0] pick;
      logic          found;
      int            idx;
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_MST; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_MST) idx = idx - NUM_MST;
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = OW'(idx);
         end
      end
      return pick;
   endfunction

   function automatic logic [OW-1:0] f_next(input logic [OW-1:0] owner);
      return (owner == OW'(NUM_MST - 1)) ? '0 : owner + 1'b1;
   endfunction

   function automatic logic [NUM_MST-1:0] f_onehot(input logic [OW-1:0] idx);
      logic [NUM_MST-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   w_state_t           r_wr_state, w_wr_state;
   logic [NUM_MST-1:0] r_wr_gnt,   w_wr_gnt;
   logic [OW-1:0]      r_wr_owner, w_wr_owner;
   logic [OW-1:0]      r_wr_ptr,   w_wr_ptr;
   logic [CW-1:0]      r_wr_cnt,   w_wr_cnt;
   logic               r_wr_to,    w_wr_to;

   r_state_t           r_rd_state, w_rd_state;
   logic [NUM_MST-1:0] r_rd_gnt,   w_rd_gnt;
   logic [OW-1:0]      r_rd_owner, w_rd_owner;
   logic [OW-1:0]      r_rd_ptr,   w_rd_ptr;
   logic [CW-1:0]      r_rd_cnt,   w_rd_cnt;
   logic               r_rd_to,    w_rd_to;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_wr_state <= W_IDLE;
         r_wr_gnt   <= '0;
         r_wr_owner <= '0;
         r_wr_ptr   <= '0;
         r_wr_cnt   <= '0;
         r_wr_to    <= 1'b0;
         r_rd_state <= R_IDLE;
         r_rd_gnt   <= '0;
         r_rd_owner <= '0;
         r_rd_ptr   <= '0;
         r_rd_cnt   <= '0;
         r_rd_to    <= 1'b0;
      end else begin
         r_wr_state <= w_wr_state;
         r_wr_gnt   <= w_wr_gnt;
         r_wr_owner <= w_wr_owner;
         r_wr_ptr   <= w_wr_ptr;
         r_wr_cnt   <= w_wr_cnt;
         r_wr_to    <= w_wr_to;
         r_rd_state <= w_rd_state;
         r_rd_gnt   <= w_rd_gnt;
         r_rd_owner <= w_rd_owner;
         r_rd_ptr   <= w_rd_ptr;
         r_rd_cnt   <= w_rd_cnt;
         r_rd_to    <= w_rd_to;
      end
   end

   // Watchdog counter defaults to 0, so every state change or handshake beat clears it;
   // only a cycle with no progress takes the increment branch. Completion is checked
   // before expiry so a coincident completion never pulses the timeout.
   always_comb begin
      w_wr_state = r_wr_state;
      w_wr_gnt   = r_wr_gnt;
      w_wr_owner = r_wr_owner;
      w_wr_ptr   = r_wr_ptr;
      w_wr_cnt   = '0;
      w_wr_to    = 1'b0;
      case (r_wr_state)
         W_IDLE: begin
            if (|i_wr_req) begin
               w_wr_owner = f_rr_pick(i_wr_req, r_wr_ptr);
               w_wr_gnt   = f_onehot(w_wr_owner);
               w_wr_state = W_ADDR;
            end
         end
         W_ADDR: begin
            if (i_awvalid && i_awready) begin
               w_wr_state = W_RESP;
            end else if (!i_wr_req[r_wr_owner]) begin
               // Abandoned request: release without advancing the pointer.
               w_wr_gnt   = '0;
               w_wr_state = W_IDLE;
            end else if (r_wr_cnt == CNT_MAX) begin
               w_wr_gnt   = '0;
               w_wr_ptr   = f_next(r_wr_owner);
               w_wr_to    = 1'b1;
               w_wr_state = W_IDLE;
            end else begin
               w_wr_cnt = r_wr_cnt + 1'b1;
            end
         end
         W_RESP: begin
            if (i_bvalid && i_bready) begin
               w_wr_gnt   = '0;
               w_wr_ptr   = f_next(r_wr_owner);
               w_wr_state = W_IDLE;
            end else if (r_wr_cnt == CNT_MAX) begin
               w_wr_gnt   = '0;
               w_wr_ptr   = f_next(r_wr_owner);
               w_wr_to    = 1'b1;
               w_wr_state = W_IDLE;
            end else begin
               w_wr_cnt = r_wr_cnt + 1'b1;
            end
         end
         default: begin
            w_wr_gnt   = '0;
            w_wr_state = W_IDLE;
         end
      endcase
   end

   always_comb begin
      w_rd_state = r_rd_state;
      w_rd_gnt   = r_rd_gnt;
      w_rd_owner = r_rd_owner;
      w_rd_ptr   = r_rd_ptr;
      w_rd_cnt   = '0;
      w_rd_to    = 1'b0;
      case (r_rd_state)
         R_IDLE: begin
            if (|i_rd_req) begin
               w_rd_owner = f_rr_pick(i_rd_req, r_rd_ptr);
               w_rd_gnt   = f_onehot(w_rd_owner);
               w_rd_state = R_ADDR;
            end
         end
         R_ADDR: begin
            if (i_arvalid && i_arready) begin
               w_rd_state = R_DATA;
            end else if (!i_rd_req[r_rd_owner]) begin
               w_rd_gnt   = '0;
               w_rd_state = R_IDLE;
            end else if (r_rd_cnt == CNT_MAX) begin
               w_rd_gnt   = '0;
               w_rd_ptr   = f_next(r_rd_owner);
               w_rd_to    = 1'b1;
               w_rd_state = R_IDLE;
            end else begin
               w_rd_cnt = r_rd_cnt + 1'b1;
            end
         end
         R_DATA: begin
            if (i_rvalid && i_rready && i_rlast) begin
               w_rd_gnt   = '0;
               w_rd_ptr   = f_next(r_rd_owner);
               w_rd_state = R_IDLE;
            end else if (i_rvalid && i_rready) begin
               w_rd_cnt = '0;   // non-final beat is progress
            end else if (r_rd_cnt == CNT_MAX) begin
               w_rd_gnt   = '0;
               w_rd_ptr   = f_next(r_rd_owner);
               w_rd_to    = 1'b1;
               w_rd_state = R_IDLE;
            end else begin
               w_rd_cnt = r_rd_cnt + 1'b1;
            end
         end
         default: begin
            w_rd_gnt   = '0;
            w_rd_state = R_IDLE;
         end
      endcase
   end

   assign o_wr_gnt     = r_wr_gnt;
   assign o_wr_owner   = r_wr_owner;
   assign o_wr_timeout = r_wr_to;
   assign o_rd_gnt     = r_rd_gnt;
   assign o_rd_owner   = r_rd_owner;
   assign o_rd_timeout = r_rd_to;

endmodule

// File: tb/tb_axi_ram_arbiter.sv
// Testbench for axi_ram_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a per-path ownership model kept in integers.
// Three masters so the round-robin wrap is not a power of two.
module tb_axi_ram_arbiter;
   localparam int N  = 3;
   localparam int TO = 8;

   logic         aclk = 1'b0;
   logic         aresetn;
   logic [N-1:0] wr_req, rd_req;
   logic         awvalid, awready, bvalid, bready;
   logic         arvalid, arready, rvalid, rready, rlast;
   logic [N-1:0] wr_gnt, rd_gnt;
   logic [1:0]   wr_owner, rd_owner;
   logic         wr_timeout, rd_timeout;

   axi_ram_arbiter #(.NUM_MST(N), .TIMEOUT(TO)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .i_wr_req(wr_req), .o_wr_gnt(wr_gnt), .o_wr_owner(wr_owner),
      .i_rd_req(rd_req), .o_rd_gnt(rd_gnt), .o_rd_owner(rd_owner),
      .i_awvalid(awvalid), .i_awready(awready), .i_bvalid(bvalid), .i_bready(bready),
      .i_arvalid(arvalid), .i_arready(arready), .i_rvalid(rvalid), .i_rready(rready),
      .i_rlast(rlast), .o_wr_timeout(wr_timeout), .o_rd_timeout(rd_timeout)
   );

   always #5 aclk = ~aclk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Model per path (0 = write, 1 = read): owner index or -1, whether the
   // address phase is done, round-robin start point, consecutive stalled edges.
   int m_own[2];
   int m_ph[2];
   int m_ptr[2];
   int m_stall[2];
   bit m_to[2];

   task automatic model_path(input int p, input bit [N-1:0] req, input bit ahs,
                             input bit beat, input bit fin);
      m_to[p] = 1'b0;
      if (!aresetn) begin
         m_own[p] = -1; m_ptr[p] = 0; m_stall[p] = 0;
         return;
      end
      if (m_own[p] < 0) begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr[p] + k) % N;
            if (req[c]) begin
               m_own[p] = c; m_ph[p] = 0; m_stall[p] = 0;
               break;
            end
         end
      end else if (m_ph[p] == 0 && ahs) begin
         m_ph[p] = 1; m_stall[p] = 0;
      end else if (m_ph[p] == 0 && !req[m_own[p]]) begin
         m_own[p] = -1;
      end else if (m_ph[p] == 1 && fin) begin
         m_ptr[p] = (m_own[p] + 1) % N; m_own[p] = -1;
      end else if (m_ph[p] == 1 && beat) begin
         m_stall[p] = 0;
      end else if (m_stall[p] + 1 == TO) begin
         m_ptr[p] = (m_own[p] + 1) % N; m_own[p] = -1; m_to[p] = 1'b1;
      end else begin
         m_stall[p]++;
      end
   endtask

   function automatic logic [N-1:0] exp_gnt(input int p);
      logic [N-1:0] v;
      v = '0;
      if (m_own[p] >= 0) v[m_own[p]] = 1'b1;
      return v;
   endfunction

   // One clock: model consumes the same inputs the DUT sampled, outputs checked 1 time unit later.
   task automatic step();
      @(posedge aclk);
      model_path(0, wr_req, awvalid && awready, bvalid && bready, bvalid && bready);
      model_path(1, rd_req, arvalid && arready, rvalid && rready, rvalid && rready && rlast);
      #1;
      chk("wr_gnt", 32'(wr_gnt), 32'(exp_gnt(0)));
      chk("wr_timeout", 32'(wr_timeout), 32'(m_to[0]));
      if (m_own[0] >= 0) chk("wr_owner", 32'(wr_owner), m_own[0]);
      chk("rd_gnt", 32'(rd_gnt), 32'(exp_gnt(1)));
      chk("rd_timeout", 32'(rd_timeout), 32'(m_to[1]));
      if (m_own[1] >= 0) chk("rd_owner", 32'(rd_owner), m_own[1]);
   endtask

   task automatic clr();
      wr_req = '0; rd_req = '0;
      awvalid = 0; awready = 0; bvalid = 0; bready = 0;
      arvalid = 0; arready = 0; rvalid = 0; rready = 0; rlast = 0;
   endtask

   int pct;

   initial begin
      for (int p = 0; p < 2; p++) begin
         m_own[p] = -1; m_ph[p] = 0; m_ptr[p] = 0; m_stall[p] = 0; m_to[p] = 0;
      end
      clr();
      aresetn = 1'b0;
      step(); step();
      chk("rst_wr_gnt", 32'(wr_gnt), 0);
      chk("rst_rd_gnt", 32'(rd_gnt), 0);
      chk("rst_wr_owner", 32'(wr_owner), 0);
      chk("rst_rd_owner", 32'(rd_owner), 0);
      aresetn = 1'b1;

      // Write round-robin: 011 -> master 0, one idle cycle, then master 1.
      wr_req = 3'b011; step();
      chk("wr_first", 32'(wr_gnt), 32'h1);
      awvalid = 1; awready = 1; step();
      awvalid = 0; awready = 0; bvalid = 1; bready = 1; step();
      chk("wr_gap", 32'(wr_gnt), 0);
      bvalid = 0; bready = 0; step();
      chk("wr_rr_next", 32'(wr_gnt), 32'h2);
      awvalid = 1; awready = 1; step();
      wr_req = '0; awvalid = 0; awready = 0; bvalid = 1; bready = 1; step();
      bvalid = 0; bready = 0;

      // Read burst of 4 beats for master 1; released only after rlast.
      rd_req = 3'b010; step();
      chk("rd_grant", 32'(rd_gnt), 32'h2);
      arvalid = 1; arready = 1; step();
      rd_req = '0; arvalid = 0; arready = 0; rvalid = 1; rready = 1;
      for (int b = 0; b < 3; b++) begin
         step();
         chk("rd_hold_beat", 32'(rd_gnt), 32'h2);
      end
      rlast = 1; step();
      chk("rd_release", 32'(rd_gnt), 0);
      rvalid = 0; rready = 0; rlast = 0; step();

      // Concurrent write and read grants, completing independently.
      wr_req = 3'b001; rd_req = 3'b010; step();
      chk("conc_wr", 32'(wr_gnt), 32'h1);
      chk("conc_rd", 32'(rd_gnt), 32'h2);
      awvalid = 1; awready = 1; arvalid = 1; arready = 1; step();
      clr(); bvalid = 1; bready = 1; step();
      chk("conc_wr_done", 32'(wr_gnt), 0);
      chk("conc_rd_still", 32'(rd_gnt), 32'h2);
      clr(); rvalid = 1; rready = 1; rlast = 1; step();
      chk("conc_rd_done", 32'(rd_gnt), 0);
      clr();

      // Watchdog: master 0 granted, AW never accepted.
      wr_req = 3'b001; step();
      chk("to_grant", 32'(wr_gnt), 32'h1);
      wr_req = 3'b011; awvalid = 1;
      for (int s = 0; s < TO - 1; s++) step();
      chk("to_not_yet", 32'(wr_timeout), 0);
      step();
      chk("to_pulse", 32'(wr_timeout), 1);
      chk("to_gnt_clear", 32'(wr_gnt), 0);
      step();
      chk("to_pulse_end", 32'(wr_timeout), 0);
      chk("to_next_master", 32'(wr_gnt), 32'h2);
      awready = 1; step();
      clr(); bvalid = 1; bready = 1; step();
      clr();

      // Reset during W_RESP drops the grant and rewinds the pointer.
      wr_req = 3'b100; step();
      awvalid = 1; awready = 1; step();
      clr(); aresetn = 1'b0; step();
      chk("rst_mid_gnt", 32'(wr_gnt), 0);
      aresetn = 1'b1; wr_req = 3'b110; step();
      chk("rst_ptr_zero", 32'(wr_gnt), 32'h2);
      awvalid = 1; awready = 1; step();
      clr(); bvalid = 1; bready = 1; step();
      clr();

      // Request dropped in W_ADDR: release without moving the pointer.
      aresetn = 1'b0; step();
      aresetn = 1'b1; wr_req = 3'b001; step();
      chk("drop_grant", 32'(wr_gnt), 32'h1);
      wr_req = 3'b000; step();
      chk("drop_clear", 32'(wr_gnt), 0);
      wr_req = 3'b011; step();
      chk("drop_ptr_kept", 32'(wr_gnt), 32'h1);
      awvalid = 1; awready = 1; step();
      clr(); bvalid = 1; bready = 1; step();
      clr();

      // Randomized traffic with shifting handshake probability.
      pct = 50;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 250 == 0) pct = int'($urandom_range(10, 90));
         if ($urandom_range(0, 3) == 0) wr_req = N'($urandom_range(0, (1 << N) - 1));
         if ($urandom_range(0, 3) == 0) rd_req = N'($urandom_range(0, (1 << N) - 1));
         awvalid = int'($urandom_range(0, 99)) < pct;
         awready = int'($urandom_range(0, 99)) < pct;
         bvalid  = int'($urandom_range(0, 99)) < pct;
         bready  = int'($urandom_range(0, 99)) < pct;
         arvalid = int'($urandom_range(0, 99)) < pct;
         arready = int'($urandom_range(0, 99)) < pct;
         rvalid  = int'($urandom_range(0, 99)) < pct;
         rready  = int'($urandom_range(0, 99)) < pct;
         rlast   = ($urandom_range(0, 2) == 0);
         aresetn = ($urandom_range(0, 399) != 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
